seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
Shares the single 4-digit seven-segment display between three requesters (e.g. result path, operand entry, error/status), so each owner keeps the display for a minimum readable time. The block selects an owner with rotating priority and an optional urgent preempt. It drives the display multiplexer's digit and dot inputs from registers. It sits between the application datapath and the seven-segment multiplexer.

Parameters:
HOLD_CYCLES, 8, minimum clk cycles an owner keeps the display before it can be switched away (must be >= 1; top level overrides with 50_000_000).
URGENT_PREEMPT, 1, when 1, requester 0 preempts any other owner immediately, ignoring the hold time.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
req  input  3  request per requester; level, held while the requester wants the display
req_digits  input  48  requester i digits at [16i+15:16i], order {thousands,hundreds,tens,ones}, 4-bit hex each
req_dot  input  9  requester i dot code at [3i+2:3i] (0 none, 1 thousands, 2 hundreds, 3 tens, 4 ones)
ack  output  3  one-cycle pulse on the requester that has just been granted
grant  output  3  one-hot current owner, 000 when the display is unowned
thousands  output  4  registered digit to the display
hundreds  output  4  registered digit to the display
tens  output  4  registered digit to the display
ones  output  4  registered digit to the display
dot  output  3  registered dot code to the display

Behaviour:
- Reset (async): grant=000, ack=000, all digit outputs=0, dot=0, hold counter=0, last-owner pointer=2 so requester 0 wins the first arbitration. State=IDLE.
- States:
  - IDLE: no owner.
  - HOLD: owner set, counter < HOLD_CYCLES.
  - OWN: owner set, hold time met.
- Round-robin: search starts at last_owner+1 mod 3 and picks the first asserted req.
- IDLE: if any req is high, grant the round-robin winner. In the same edge, latch its digits and dot into the outputs, pulse its ack, clear the counter, and go to HOLD. Latency from req rise to grant/outputs is 1 cycle.
- HOLD: the counter increments each cycle. Outputs track the owner's slot every cycle (live update) while its req is high. If the owner drops req, outputs freeze at the last values, and the hold time is still honoured. When counter==HOLD_CYCLES-1, go to OWN on the next edge.
- OWN:
  - If another requester is high, switch to its round-robin winner (same actions as the IDLE grant) and go to HOLD.
  - Else if the owner's req is high, stay in OWN with live update.
  - Else set grant=000 and go to IDLE; outputs retain the last values (no blanking).
- Preempt (URGENT_PREEMPT=1): in HOLD or OWN with another owner, req[0] high forces an immediate grant to 0 next edge, with ack[0] pulse, counter reset and state HOLD. Requester 0 as owner is never preempted.
- Simultaneous requests: one grant per edge, and ack is one-hot or zero.
- Ownership: the owner re-raising req causes no new ack. A requester that dropped and re-raised req while still owner keeps ownership without a new ack.
- Counter width: clog2(HOLD_CYCLES+1). The counter saturates in OWN.
- Reset mid-operation: everything returns to reset values immediately, independent of clk.

Test Plan:
- Reset, then req=001, digits0=16'h1234, dot0=2: next cycle grant=001, ack=001 for 1 cycle, thousands..ones=1,2,3,4, dot=2.
- Owner 1 is in HOLD and req[2] rises at cycle 2 after grant: grant stays 010 until 8 cycles after grant, then becomes 100 with ack=100 and digits switching to slot 2.
- req=110 simultaneously from IDLE with last owner 2: grant 010 first. After the hold, grant 100. Then with req=110 still high, grant 010 (rotation).
- URGENT_PREEMPT=1, owner 2 at hold cycle 3, req[0] rises: next edge grant=001, ack=001, and outputs show slot 0 digits.
- Owner drops req at hold cycle 2 with digits 16'hABCD: outputs hold A,B,C,D; grant stays set until the hold expires, then grant=000 and outputs still show A,B,C,D.
- Assert reset while in OWN with dot=4: grant, ack, digits and dot all read 0 before the next clk edge.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Shares one 4-digit seven-segment display among three requesters with
// rotating priority, a minimum hold time and an optional urgent preempt.
module seg7_display_arbiter #(
    parameter int HOLD_CYCLES    = 8,
    parameter bit URGENT_PREEMPT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] req_digits,
    input  logic [8:0]  req_dot,
    output logic [2:0]  ack,
    output logic [2:0]  grant,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic [2:0]  dot
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

    state_t        state_q, state_n;
    logic [2:0]    grant_q, grant_n;
    logic [2:0]    ack_q, ack_n;
    logic [15:0]   disp_q, disp_n;
    logic [2:0]    dot_q, dot_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [1:0]    last_q, last_n;

    logic [2:0] cand;
    logic [1:0] o0, o1, o2;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] own_idx;
    logic       own_req;
    logic       hold_done;
    logic       g_do;
    logic [1:0] g_idx;

    function automatic logic [15:0] pick16(input logic [47:0] v,
                                           input logic [1:0] i);
        case (i)
            2'd1:    return v[31:16];
            2'd2:    return v[47:32];
            default: return v[15:0];
        endcase
    endfunction

    function automatic logic [2:0] pick3(input logic [8:0] v,
                                         input logic [1:0] i);
        case (i)
            2'd1:    return v[5:3];
            2'd2:    return v[8:6];
            default: return v[2:0];
        endcase
    endfunction

    // Round-robin search begins just after the last owner.
    always_comb begin
        cand = req & ~grant_q;
        case (last_q)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        win_vld = |cand;
        if (cand[o0])      win_idx = o0;
        else if (cand[o1]) win_idx = o1;
        else               win_idx = o2;
    end

    always_comb begin
        if (grant_q[2])      own_idx = 2'd2;
        else if (grant_q[1]) own_idx = 2'd1;
        else                 own_idx = 2'd0;
        own_req   = |(req & grant_q);
        hold_done = (state_q == OWN) || (cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        ack_n   = 3'b000;
        disp_n  = disp_q;
        dot_n   = dot_q;
        cnt_n   = cnt_q;
        last_n  = last_q;
        g_do    = 1'b0;
        g_idx   = win_idx;
        case (state_q)
            IDLE: begin
                if (win_vld) g_do = 1'b1;
            end
            HOLD, OWN: begin
                if (own_req) begin
                    disp_n = pick16(req_digits, own_idx);
                    dot_n  = pick3(req_dot, own_idx);
                end
                if (URGENT_PREEMPT && req[0] && !grant_q[0]) begin
                    g_do  = 1'b1;
                    g_idx = 2'd0;
                end else if (hold_done) begin
                    if (win_vld) begin
                        g_do = 1'b1;
                    end else if (own_req) begin
                        state_n = OWN;
                        cnt_n   = HOLD_SAT;
                    end else begin
                        state_n = IDLE;
                        grant_n = 3'b000;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // A new grant overrides any live update from the previous owner.
        if (g_do) begin
            grant_n = 3'b001 << g_idx;
            ack_n   = 3'b001 << g_idx;
            disp_n  = pick16(req_digits, g_idx);
            dot_n   = pick3(req_dot, g_idx);
            cnt_n   = '0;
            state_n = HOLD;
            last_n  = g_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            ack_q   <= 3'b000;
            disp_q  <= 16'h0000;
            dot_q   <= 3'd0;
            cnt_q   <= '0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            ack_q   <= ack_n;
            disp_q  <= disp_n;
            dot_q   <= dot_n;
            cnt_q   <= cnt_n;
            last_q  <= last_n;
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign thousands = disp_q[15:12];
    assign hundreds  = disp_q[11:8];
    assign tens      = disp_q[7:4];
    assign ones      = disp_q[3:0];
    assign dot       = dot_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter (HOLD_CYCLES=8, preempt on).
module tb_seg7_display_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [47:0] req_digits = '0;
    logic [8:0]  req_dot = '0;
    logic [2:0]  ack, grant;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic [2:0]  dot;

    int n_chk = 0;
    int n_fail = 0;

    seg7_display_arbiter #(.HOLD_CYCLES(8), .URGENT_PREEMPT(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .req_digits(req_digits),
        .req_dot(req_dot), .ack(ack), .grant(grant),
        .thousands(thousands), .hundreds(hundreds), .tens(tens),
        .ones(ones), .dot(dot)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b000, 3'b000, 16'h0000, 3'd0}) begin
            n_fail++;
            $display("FAIL reset: g=%b a=%b d=%h%h%h%h dot=%0d want all 0",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_grant;
        req_digits[15:0] = 16'h1234;
        req_dot[2:0] = 3'd2;
        req = 3'b001;
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b001, 3'b001, 16'h1234, 3'd2}) begin
            n_fail++;
            $display("FAIL basic_grant: g=%b a=%b d=%h%h%h%h dot=%0d want 001 001 1234 2",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        req = 3'b000;
        tick(1);
        n_chk++;
        if ({grant, ack} !== {3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_ack_pulse: g=%b a=%b want 001 000", grant, ack);
        end
        tick(6);
        n_chk++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_hold_end: g=%b want 001", grant);
        end
        tick(1);
        n_chk++;
        if ({grant, thousands, hundreds, tens, ones}
            !== {3'b000, 16'h1234}) begin
            n_fail++;
            $display("FAIL basic_release: g=%b d=%h%h%h%h want 000 1234",
                     grant, thousands, hundreds, tens, ones);
        end
    endtask

    task automatic test_hold_switch;
        req_digits[31:16] = 16'h5678;
        req_dot[5:3] = 3'd1;
        req_digits[47:32] = 16'h9ABC;
        req_dot[8:6] = 3'd3;
        req = 3'b010;
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b010, 3'b010, 16'h5678, 3'd1}) begin
            n_fail++;
            $display("FAIL hold_grant1: g=%b a=%b d=%h%h%h%h dot=%0d want 010 010 5678 1",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        tick(2);
        req = 3'b110;
        for (int c = 3; c < 8; c++) begin
            tick(1);
            n_chk++;
            if ({grant, ack} !== {3'b010, 3'b000}) begin
                n_fail++;
                $display("FAIL hold_keep c%0d: g=%b a=%b want 010 000",
                         c, grant, ack);
            end
        end
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b100, 3'b100, 16'h9ABC, 3'd3}) begin
            n_fail++;
            $display("FAIL hold_switch: g=%b a=%b d=%h%h%h%h dot=%0d want 100 100 9abc 3",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        req = 3'b000;
        tick(8);
        n_chk++;
        if (grant !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_idle: g=%b want 000", grant);
        end
    endtask

    task automatic test_rotation;
        req_digits[31:16] = 16'h2468;
        req_dot[5:3] = 3'd4;
        req_digits[47:32] = 16'h1357;
        req_dot[8:6] = 3'd0;
        req = 3'b110;
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b010, 3'b010, 16'h2468, 3'd4}) begin
            n_fail++;
            $display("FAIL rot_first: g=%b a=%b d=%h%h%h%h dot=%0d want 010 010 2468 4",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        tick(7);
        n_chk++;
        if (grant !== 3'b010) begin
            n_fail++;
            $display("FAIL rot_hold1: g=%b want 010", grant);
        end
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b100, 3'b100, 16'h1357, 3'd0}) begin
            n_fail++;
            $display("FAIL rot_second: g=%b a=%b d=%h%h%h%h dot=%0d want 100 100 1357 0",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        tick(7);
        n_chk++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL rot_hold2: g=%b want 100", grant);
        end
        tick(1);
        n_chk++;
        if ({grant, ack} !== {3'b010, 3'b010}) begin
            n_fail++;
            $display("FAIL rot_back: g=%b a=%b want 010 010", grant, ack);
        end
        req = 3'b000;
        tick(8);
        n_chk++;
        if (grant !== 3'b000) begin
            n_fail++;
            $display("FAIL rot_idle: g=%b want 000", grant);
        end
    endtask

    task automatic test_preempt;
        req_digits[47:32] = 16'h0F0E;
        req_dot[8:6] = 3'd1;
        req_digits[15:0] = 16'hCAFE;
        req_dot[2:0] = 3'd3;
        req = 3'b100;
        tick(1);
        n_chk++;
        if ({grant, ack} !== {3'b100, 3'b100}) begin
            n_fail++;
            $display("FAIL pre_owner2: g=%b a=%b want 100 100", grant, ack);
        end
        tick(3);
        req = 3'b101;
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b001, 3'b001, 16'hCAFE, 3'd3}) begin
            n_fail++;
            $display("FAIL preempt: g=%b a=%b d=%h%h%h%h dot=%0d want 001 001 cafe 3",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        tick(7);
        n_chk++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_hold0: g=%b want 001", grant);
        end
        req = 3'b000;
        tick(2);
        n_chk++;
        if (grant !== 3'b000) begin
            n_fail++;
            $display("FAIL pre_idle: g=%b want 000", grant);
        end
    endtask

    task automatic test_drop_freeze;
        req_digits[31:16] = 16'h9999;
        req_dot[5:3] = 3'd2;
        req = 3'b010;
        tick(1);
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones}
            !== {3'b010, 3'b010, 16'h9999}) begin
            n_fail++;
            $display("FAIL drop_grant: g=%b a=%b d=%h%h%h%h want 010 010 9999",
                     grant, ack, thousands, hundreds, tens, ones);
        end
        req_digits[31:16] = 16'hABCD;
        tick(1);
        n_chk++;
        if ({thousands, hundreds, tens, ones} !== 16'hABCD) begin
            n_fail++;
            $display("FAIL live_update: d=%h%h%h%h want abcd",
                     thousands, hundreds, tens, ones);
        end
        tick(1);
        req = 3'b000;
        req_digits[31:16] = 16'h1111;
        tick(5);
        n_chk++;
        if ({grant, thousands, hundreds, tens, ones} !== {3'b010, 16'hABCD}) begin
            n_fail++;
            $display("FAIL drop_hold: g=%b d=%h%h%h%h want 010 abcd",
                     grant, thousands, hundreds, tens, ones);
        end
        tick(1);
        n_chk++;
        if ({grant, thousands, hundreds, tens, ones, dot}
            !== {3'b000, 16'hABCD, 3'd2}) begin
            n_fail++;
            $display("FAIL drop_release: g=%b d=%h%h%h%h dot=%0d want 000 abcd 2",
                     grant, thousands, hundreds, tens, ones, dot);
        end
    endtask

    task automatic test_reset_in_own;
        req_digits[15:0] = 16'h4321;
        req_dot[2:0] = 3'd4;
        req = 3'b001;
        tick(10);
        n_chk++;
        if ({grant, dot, thousands, hundreds, tens, ones}
            !== {3'b001, 3'd4, 16'h4321}) begin
            n_fail++;
            $display("FAIL own_state: g=%b dot=%0d d=%h%h%h%h want 001 4 4321",
                     grant, dot, thousands, hundreds, tens, ones);
        end
        reset = 1'b1;
        #2;
        n_chk++;
        if ({grant, ack, thousands, hundreds, tens, ones, dot}
            !== {3'b000, 3'b000, 16'h0000, 3'd0}) begin
            n_fail++;
            $display("FAIL async_reset: g=%b a=%b d=%h%h%h%h dot=%0d want all 0",
                     grant, ack, thousands, hundreds, tens, ones, dot);
        end
        req = 3'b000;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_grant;
        test_hold_switch;
        test_rotation;
        test_preempt;
        test_drop_freeze;
        test_reset_in_own;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
